// File: rtl/ecc_hamming_74_scrubber_if.sv
// -----------------------------------------------------------------------------
// ecc_hamming_74_scrubber_if
//
// Purpose:
//   Word-wide req/ack memory port used by the (7,4)+parity scrubber. The
//   scrubber is the master. It holds mem_req, and keeps mem_we, mem_addr and
//   mem_wdata stable, until the memory answers with mem_ack. On a read,
//   mem_rdata is valid in the same cycle as mem_ack.
//
// Parameters:
//   AW        word address width; must match the scrubber's AW
//
// Signals:
//   mem_req   master -> slave  request, held until mem_ack
//   mem_we    master -> slave  1 = write, 0 = read; qualified by mem_req
//   mem_addr  master -> slave  word address
//   mem_wdata master -> slave  [6:0] codeword, [7] extra parity
//   mem_ack   slave  -> master request accepted this cycle
//   mem_rdata slave  -> master read word, same format as mem_wdata
// -----------------------------------------------------------------------------
interface ecc_hamming_74_scrubber_if #(
    parameter int AW = 4
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic [7:0]    mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/ecc_hamming_74_scrubber.sv
// -----------------------------------------------------------------------------
// ecc_hamming_74_scrubber
//
// Purpose:
//   Background scrubber for a memory of Hamming (7,4) words that carry one
//   extra overall-parity bit. Each pass reads addresses 0..DEPTH-1 and decodes
//   every word inline:
//     - a clean word is left alone;
//     - a single-bit error is corrected and the fixed word is written back;
//     - a double-bit error is counted as uncorrectable (UE). The first UE
//       address since reset/clr is captured for software.
//
// Word format (bit i of the codeword is Hamming position i+1):
//   [0] p1  [1] p2  [2] d0  [3] p4  [4] d1  [5] d2  [6] d3  [7] extra parity
//
// Optional feature (compile-time macro ECC_SCRUB_AUTO_EN):
//   When defined, each DONE loads a down-counter with INTERVAL. The counter
//   counts down in IDLE and launches a new pass when it reaches zero. A start
//   during the countdown launches a pass at once. When undefined, passes begin
//   only on start and no counter logic exists.
//
// Parameters:
//   DEPTH     words per pass (need not be a power of two)
//   CW        width of the saturating error counters
//   INTERVAL  idle cycles between automatic passes (ECC_SCRUB_AUTO_EN only)
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   start     pulse: begin one pass; ignored unless IDLE
//   clr       clear ce_count, ue_count, ue_flag, ue_addr (wins over increments)
//   busy      pass in progress
//   done      one-cycle pulse at end of pass
//   mem       req/ack memory port (master side)
//   ce_count  corrected-error count, saturating
//   ue_count  uncorrectable-error count, saturating
//   ue_flag   sticky: at least one UE since reset/clr
//   ue_addr   address of the first UE since reset/clr
// -----------------------------------------------------------------------------
module ecc_hamming_74_scrubber #(
    parameter  int DEPTH    = 16,
    parameter  int CW       = 8,
    parameter  int INTERVAL = 1024,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              clr,
    output logic                              busy,
    output logic                              done,
    ecc_hamming_74_scrubber_if.master         mem,
    output logic [CW-1:0]                     ce_count,
    output logic [CW-1:0]                     ue_count,
    output logic                              ue_flag,
    output logic [AW-1:0]                     ue_addr
);

    // Reject configurations that cannot work, at elaboration time.
    if (DEPTH < 1) begin : g_bad_depth
        $error("ecc_hamming_74_scrubber: DEPTH must be at least 1");
    end
    if (CW < 1) begin : g_bad_cw
        $error("ecc_hamming_74_scrubber: CW must be at least 1");
    end
    if (INTERVAL < 0) begin : g_bad_interval
        $error("ecc_hamming_74_scrubber: INTERVAL must not be negative");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_WRITE = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    rdata_q;
    logic [7:0]    wdata_q;
    logic          req_q;
    logic          we_q;
    logic          busy_q;
    logic          done_q;

    logic [CW-1:0] ce_q;
    logic [CW-1:0] ue_q;
    logic          ue_flag_q;
    logic [AW-1:0] ue_addr_q;

    logic          launch;

    // -------------------------------------------------------------------------
    // Inline SECDED decode of the latched read word.
    // s1 covers positions 1,3,5,7; s2 covers 2,3,6,7; s4 covers 4,5,6,7.
    // The overall parity covers all eight bits, so an odd count of flipped bits
    // (one, in practice) shows up as parity = 1. In that case the syndrome
    // names the bad position. A zero syndrome means the extra parity bit
    // itself flipped.
    // -------------------------------------------------------------------------
    logic [2:0] syndrome;
    logic       parity;
    logic [7:0] flip_mask;
    logic       single_err;
    logic       double_err;
    logic [7:0] fixed_word;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        syndrome  = 3'd0;
        parity    = 1'b0;
        flip_mask = 8'h00;

        syndrome[0] = rdata_q[0] ^ rdata_q[2] ^ rdata_q[4] ^ rdata_q[6];
        syndrome[1] = rdata_q[1] ^ rdata_q[2] ^ rdata_q[5] ^ rdata_q[6];
        syndrome[2] = rdata_q[3] ^ rdata_q[4] ^ rdata_q[5] ^ rdata_q[6];
        parity      = ^rdata_q;

        if (syndrome == 3'd0) begin
            flip_mask = 8'h80;
        end else begin
            flip_mask = 8'h01 << (syndrome - 3'd1);
        end
    end

    assign single_err = parity;
    assign double_err = !parity && (syndrome != 3'd0);
    assign fixed_word = rdata_q ^ flip_mask;

    // -------------------------------------------------------------------------
    // Pass launch: manual start, or an expired auto-scrub countdown.
    // -------------------------------------------------------------------------
`ifdef ECC_SCRUB_AUTO_EN
    localparam int TW = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;

    logic [TW-1:0] tmr_q;
    logic          armed_q;

    assign launch = (state_q == S_IDLE) && (start || (armed_q && (tmr_q == '0)));

    // The countdown is armed by each DONE and disarmed by any launch. A manual
    // start during the countdown reloads the counter as it launches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q   <= '0;
            armed_q <= 1'b0;
        end else if (launch) begin
            tmr_q   <= TW'(INTERVAL);
            armed_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            tmr_q   <= TW'(INTERVAL);
            armed_q <= 1'b1;
        end else if (armed_q && (tmr_q != '0)) begin
            tmr_q   <= tmr_q - TW'(1);
        end
    end
`else
    assign launch = (state_q == S_IDLE) && start;
`endif

    // -------------------------------------------------------------------------
    // Scrub FSM. All bus-facing outputs are registered here. Once mem_req is
    // raised, mem_addr, mem_we and mem_wdata stay put until mem_ack arrives.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rdata_q <= 8'h00;
            wdata_q <= 8'h00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments, so every
            // right-hand side sees the pre-edge value regardless of order.
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q <= S_READ;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                    end
                end

                S_READ: begin
                    if (mem.mem_ack) begin
                        rdata_q <= mem.mem_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (single_err) begin
                        wdata_q <= fixed_word;
                        we_q    <= 1'b1;
                        req_q   <= 1'b1;
                        state_q <= S_WRITE;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end

                S_WRITE: begin
                    if (mem.mem_ack) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (addr_q == LAST_ADDR) begin
                        addr_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= addr_q + AW'(1);
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        state_q <= S_READ;
                    end
                end

                // Start is deliberately not sampled here.
                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Error statistics. They update during the single CHECK cycle of each word.
    // clr has priority over a coincident increment. It does not touch the pass
    // itself.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q      <= '0;
            ue_q      <= '0;
            ue_flag_q <= 1'b0;
            ue_addr_q <= '0;
        end else if (clr) begin
            ce_q      <= '0;
            ue_q      <= '0;
            ue_flag_q <= 1'b0;
            ue_addr_q <= '0;
        end else if (state_q == S_CHECK) begin
            if (single_err && (ce_q != '1)) begin
                ce_q <= ce_q + CW'(1);
            end
            if (double_err) begin
                if (ue_q != '1) begin
                    ue_q <= ue_q + CW'(1);
                end
                ue_flag_q <= 1'b1;
                // Only the first UE since reset/clr is recorded.
                if (!ue_flag_q) begin
                    ue_addr_q <= addr_q;
                end
            end
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign busy     = busy_q;
    assign done     = done_q;
    assign ce_count = ce_q;
    assign ue_count = ue_q;
    assign ue_flag  = ue_flag_q;
    assign ue_addr  = ue_addr_q;

endmodule

// File: tb/tb_ecc_hamming_74_scrubber.sv
// -----------------------------------------------------------------------------
// tb_ecc_hamming_74_scrubber
//
// Self-checking bench for ecc_hamming_74_scrubber (DEPTH=8, CW=2).
// A memory responder answers requests after a random number of wait cycles.
// Before each pass, a reference model classifies every stored word by its
// Hamming distance to the 16 legal codewords. It queues the expected memory
// transactions and the expected end-of-pass statistics. A monitor pops and
// compares those whenever the DUT completes a transaction or pulses done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ecc_hamming_74_scrubber;

    localparam int DEPTH  = 8;
    localparam int CW     = 2;
    localparam int AW     = 3;
    localparam int CNTMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } txn_t;

    typedef struct packed {
        logic [CW-1:0] ce;
        logic [CW-1:0] ue;
        logic          flag;
        logic [AW-1:0] ua;
    } stat_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          clr;
    logic          busy;
    logic          done;
    logic [CW-1:0] ce_count;
    logic [CW-1:0] ue_count;
    logic          ue_flag;
    logic [AW-1:0] ue_addr;

    ecc_hamming_74_scrubber_if #(.AW(AW)) mem_if ();

    ecc_hamming_74_scrubber #(
        .DEPTH    (DEPTH),
        .CW       (CW),
        .INTERVAL (16)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clr      (clr),
        .busy     (busy),
        .done     (done),
        .mem      (mem_if),
        .ce_count (ce_count),
        .ue_count (ue_count),
        .ue_flag  (ue_flag),
        .ue_addr  (ue_addr)
    );

    int   total = 0;
    int   bad   = 0;

    logic [7:0] mem [DEPTH];
    txn_t  exp_txn_q [$];
    stat_t exp_stat_q[$];

    bit sb_en   = 1'b1;
    bit hold_wr = 1'b0;

    int m_ce, m_ue, m_ua;
    bit m_flag;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Build a legal word from the placement rule: data go to positions 3,5,6,7.
    // Parity position k covers every other position whose index has bit k set.
    // The extra bit makes the total parity even.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] w;
        int dpos[4];
        int kpos[3];
        logic par;
        dpos = '{3, 5, 6, 7};
        kpos = '{1, 2, 4};
        w = 8'h00;
        for (int i = 0; i < 4; i++) w[dpos[i]-1] = d[i];
        for (int j = 0; j < 3; j++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos & kpos[j]) != 0) && (pos != kpos[j])) par ^= w[pos-1];
            w[kpos[j]-1] = par;
        end
        w[7] = ^w[6:0];
        return w;
    endfunction

    // 0 = clean, 1 = correctable (fix holds the nearest codeword), 2 = UE.
    function automatic int classify(input logic [7:0] w, output logic [7:0] fix);
        int kind;
        logic [7:0] c;
        kind = 2;
        fix  = w;
        for (int d = 0; d < 16; d++) begin
            c = encode(4'(d));
            if ($countones(w ^ c) == 0) begin kind = 0; fix = c; end
            if ($countones(w ^ c) == 1) begin kind = 1; fix = c; end
        end
        return kind;
    endfunction

    function automatic logic [7:0] rand_word();
        logic [7:0] w;
        int k, b1, b2;
        w = encode(4'($urandom_range(0, 15)));
        k = $urandom_range(0, 3);
        if (k == 1) begin
            w[$urandom_range(0, 7)] ^= 1'b1;
        end else if (k == 2) begin
            b1 = $urandom_range(0, 7);
            b2 = (b1 + 1 + $urandom_range(0, 6)) % 8;
            w[b1] ^= 1'b1;
            w[b2] ^= 1'b1;
        end
        return w;
    endfunction

    // Predict one full pass over the current memory contents. A clr asserted
    // in the check cycle of word clr_at zeroes the statistics after that word.
    task automatic model_pass(input int clr_at);
        txn_t t;
        stat_t s;
        logic [7:0] fix;
        int kind;
        for (int a = 0; a < DEPTH; a++) begin
            t.we = 1'b0; t.addr = AW'(a); t.data = 8'h00;
            exp_txn_q.push_back(t);
            kind = classify(mem[a], fix);
            if (kind == 1) begin
                t.we = 1'b1; t.addr = AW'(a); t.data = fix;
                exp_txn_q.push_back(t);
                if (m_ce < CNTMAX) m_ce++;
            end else if (kind == 2) begin
                if (m_ue < CNTMAX) m_ue++;
                if (!m_flag) begin m_flag = 1'b1; m_ua = a; end
            end
            if (a == clr_at) begin m_ce = 0; m_ue = 0; m_flag = 1'b0; m_ua = 0; end
        end
        s.ce = CW'(m_ce); s.ue = CW'(m_ue); s.flag = m_flag; s.ua = AW'(m_ua);
        exp_stat_q.push_back(s);
    endtask

    // Memory responder: random 0..2 wait cycles before each ack. The first
    // request is answered after exactly one wait cycle.
    initial begin
        int waitc;
        int target;
        waitc  = 0;
        target = 1;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_if.mem_ack = 1'b0;
            if (!rst_n) begin
                waitc = 0;
            end else if (mem_if.mem_req && !(hold_wr && mem_if.mem_we)) begin
                if (waitc < target) begin
                    waitc++;
                end else begin
                    mem_if.mem_ack = 1'b1;
                    if (mem_if.mem_we) mem[mem_if.mem_addr] = mem_if.mem_wdata;
                    else               mem_if.mem_rdata = mem[mem_if.mem_addr];
                    waitc  = 0;
                    target = $urandom_range(0, 2);
                end
            end
        end
    end

    // Monitor: compares every accepted transaction and every done pulse.
    initial begin
        txn_t  t;
        stat_t s;
        forever begin
            @(negedge clk);
            #1;
            if (sb_en && rst_n && mem_if.mem_req && mem_if.mem_ack) begin
                if (exp_txn_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_txn: got we=%0b addr=%0d expected none", mem_if.mem_we, mem_if.mem_addr);
                end else begin
                    t = exp_txn_q.pop_front();
                    check("txn_we", 32'(mem_if.mem_we), 32'(t.we));
                    check("txn_addr", 32'(mem_if.mem_addr), 32'(t.addr));
                    if (t.we) check("txn_wdata", 32'(mem_if.mem_wdata), 32'(t.data));
                end
            end
            if (sb_en && rst_n && done) begin
                if (exp_stat_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    s = exp_stat_q.pop_front();
                    check("done_busy", 32'(busy), 32'd0);
                    check("ce_count", 32'(ce_count), 32'(s.ce));
                    check("ue_count", 32'(ue_count), 32'(s.ue));
                    check("ue_flag", 32'(ue_flag), 32'(s.flag));
                    check("ue_addr", 32'(ue_addr), 32'(s.ua));
                end
            end
        end
    end

    task automatic clr_stats();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        m_ce = 0; m_ue = 0; m_flag = 1'b0; m_ua = 0;
    endtask

    task automatic fill(input logic [7:0] w);
        for (int a = 0; a < DEPTH; a++) mem[a] = w;
    endtask

    // One pass. poke = pulse start mid-pass and again in the DONE cycle (both
    // must be ignored). clr_at >= 0 asserts clr in that word's check cycle.
    task automatic run_pass(input int clr_at, input bit poke);
        int cyc;
        bit got_done;
        bit clr_pending;
        model_pass(clr_at);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        got_done = 1'b0;
        clr_pending = (clr_at >= 0);
        while (cyc < 2000 && !got_done) begin
            @(negedge clk);
            #2;
            cyc++;
            start = (poke && cyc == 5);
            if (done) begin
                got_done = 1'b1;
            end else if (clr_pending && mem_if.mem_req && mem_if.mem_ack &&
                         !mem_if.mem_we && (mem_if.mem_addr == AW'(clr_at))) begin
                @(negedge clk); clr = 1'b1;
                @(negedge clk); clr = 1'b0;
                clr_pending = 1'b0;
            end
        end
        start = 1'b0;
        if (!got_done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done pulse expected one within 2000 cycles");
            exp_txn_q.delete();
            exp_stat_q.delete();
        end else if (poke) begin
            start = 1'b1;
            @(negedge clk); #2;
            start = 1'b0;
            @(negedge clk); #2;
            check("start_at_done_busy", 32'(busy), 32'd0);
            check("start_at_done_req", 32'(mem_if.mem_req), 32'd0);
        end else begin
            @(negedge clk);
        end
        check("txn_queue_drained", 32'(exp_txn_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        m_ce = 0; m_ue = 0; m_flag = 1'b0; m_ua = 0;
        fill(8'hD2);

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(mem_if.mem_req), 32'd0);
        check("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        check("rst_ce", 32'(ce_count), 32'd0);
        check("rst_ue", 32'(ue_count), 32'd0);
        check("rst_flag", 32'(ue_flag), 32'd0);
        check("rst_ue_addr", 32'(ue_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean memory: eight reads, no writes.
        fill(8'hD2);
        run_pass(-1, 1'b1);

        // Position 5 flipped at addr 3.
        clr_stats();
        fill(8'hD2); mem[3] = 8'hC2;
        run_pass(-1, 1'b0);
        check("fixed_addr3", 32'(mem[3]), 32'hD2);

        // Extra parity bit flipped at addr 2.
        clr_stats();
        fill(8'hD2); mem[2] = 8'h52;
        run_pass(-1, 1'b0);

        // Double errors at addr 5 and 6: first UE address is 5.
        clr_stats();
        fill(8'hD2); mem[5] = 8'hD1; mem[6] = 8'hD1;
        run_pass(-1, 1'b0);

        // Five corrected words saturate the 2-bit counter at 3.
        clr_stats();
        fill(8'hD2);
        for (int a = 0; a < 5; a++) mem[a] = 8'hC2;
        run_pass(-1, 1'b0);

        // clr during the check cycle of a single error wins over the increment.
        clr_stats();
        fill(8'hD2); mem[0] = 8'hC2;
        run_pass(0, 1'b0);

        // Randomised passes; statistics accumulate and saturate across passes.
        clr_stats();
        for (int p = 0; p < 12; p++) begin
            if ($urandom_range(0, 3) == 0) clr_stats();
            for (int a = 0; a < DEPTH; a++) mem[a] = rand_word();
            run_pass(-1, bit'(p % 3 == 0));
        end

        // Reset while a write waits for its ack.
        clr_stats();
        fill(8'hD2); mem[0] = 8'hC2;
        sb_en   = 1'b0;
        hold_wr = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (cyc < 200 && !(mem_if.mem_req && mem_if.mem_we)) begin
            @(negedge clk); #2;
            cyc++;
        end
        check("write_reached", 32'(mem_if.mem_req && mem_if.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(mem_if.mem_req), 32'd0);
        check("arst_we", 32'(mem_if.mem_we), 32'd0);
        check("arst_addr", 32'(mem_if.mem_addr), 32'd0);
        check("arst_wdata", 32'(mem_if.mem_wdata), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ce", 32'(ce_count), 32'd0);
        check("arst_ue", 32'(ue_count), 32'd0);
        check("arst_flag", 32'(ue_flag), 32'd0);
        check("arst_ue_addr", 32'(ue_addr), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        hold_wr = 1'b0;
        exp_txn_q.delete();
        exp_stat_q.delete();
        m_ce = 0; m_ue = 0; m_flag = 1'b0; m_ua = 0;
        sb_en = 1'b1;
        run_pass(-1, 1'b0);
        check("post_reset_fix", 32'(mem[0]), 32'hD2);

        repeat (3) @(negedge clk);
        check("stat_queue_drained", 32'(exp_stat_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_hamming_74_scrubber.md
Name: ecc_hamming_74_scrubber

Overview:
- Background scrubber that sits downstream of the (7,4) SECDED decoder, on a memory holding (7,4)+extra-parity words.
- Walks addresses 0..DEPTH-1 and reads each word through a req/ack port.
- Decodes each word inline; writes the corrected word back on a single-bit error.
- Counts corrected and uncorrectable errors, and captures the first uncorrectable address for software.

Parameters:
- DEPTH, 16, number of words scrubbed per pass (need not be a power of 2); AW = $clog2(DEPTH), minimum 1.
- CW, 8, width of the error counters.
- INTERVAL, 1024, idle cycles between automatic passes (used only with ECC_SCRUB_AUTO_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin one pass; ignored while busy
- clr  in  1  clear ce_count, ue_count, ue_flag, ue_addr
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  AW  word address
- mem_wdata  out  8  write word: [6:0] codeword, [7] extra parity
- mem_ack  in  1  request accepted; on a read, mem_rdata is valid in the same cycle
- mem_rdata  in  8  read word, same format as mem_wdata
- ce_count  out  CW  corrected-error count, saturating
- ue_count  out  CW  uncorrectable-error count, saturating
- ue_flag  out  1  sticky: at least one UE since reset/clr
- ue_addr  out  AW  address of first UE since reset/clr

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; address 0. Reset is async, so mem_req drops immediately, including mid-transaction.
- Word format:
  - codeword[i] is Hamming position i+1; parity bits at positions 1, 2, 4.
  - data d0..d3 at positions 3, 5, 6, 7.
  - extra parity = XOR of codeword[6:0].
- Decode:
  - s = {s4, s2, s1}, where s_k = XOR of positions whose index has bit k set.
  - p = XOR of all 8 bits.
  - s=0, p=0: clean.
  - p=1: single error. If s≠0, flip position s; if s=0, flip bit 7.
  - s≠0, p=0: double error (UE).
- FSM states:
  - IDLE: start → READ at addr 0, busy=1.
  - READ: mem_req=1, mem_we=0. Wait for mem_ack, latch mem_rdata → CHECK.
  - CHECK (1 cycle):
    - clean → NEXT.
    - single → ce_count+1 → WRITE.
    - double → ue_count+1 and ue_flag=1; load ue_addr if ue_flag was 0 → NEXT.
  - WRITE: mem_req=1, mem_we=1, mem_wdata = corrected word. Wait for mem_ack → NEXT.
  - NEXT: if addr == DEPTH-1, go to DONE with addr reset to 0; else addr+1 → READ.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ack=0.
  - mem_ack is ignored when mem_req=0.
- Timing: clean word costs (read wait + 1) + 2 cycles; a corrected word adds the write wait + 1.
- Counters saturate at all-ones; ue_flag and ue_addr are unaffected by saturation.
- clr in the same cycle as an increment: clr wins, and the register reads 0 next cycle. clr does not abort a pass.
- start while busy is ignored; start coincident with DONE is ignored.

Optional Feature:
- Macro: ECC_SCRUB_AUTO_EN.
- Defined:
  - After DONE, a down-counter loads INTERVAL, decrements in IDLE, and starts a new pass at 0.
  - start during countdown begins a pass immediately and reloads the counter.
  - INTERVAL=0 means back-to-back passes.
- Undefined: no counter logic; passes begin only on start.

Test Plan:
- DEPTH=8, all words 8'hD2 (data 4'hA), ack after 1 wait → 8 reads, 0 writes, done pulse, ce_count=0, ue_count=0.
- Addr 3 = 8'hC2 (position 5 flipped) → one write to addr 3 with 8'hD2, ce_count=1, ue_flag=0.
- Addr 2 = 8'h52 (extra parity flipped) → write 8'hD2 to addr 2, ce_count=1.
- Addr 5 and 6 = 8'hD1 (positions 1 and 2 flipped) → no writes, ue_count=2, ue_flag=1, ue_addr=5.
- rst_n low while in WRITE awaiting ack → mem_req=0 the same cycle, all outputs 0. A new start then completes a full pass.
- clr asserted in the CHECK cycle of a single error → ce_count=0 afterwards. With CW=2 and 5 CE words → ce_count=3 (saturated).
